// File: rtl/ysyx_22040759_if_axi_rd.sv
// Instruction-fetch read bridge: converts one IF fetch request (valid/addr/size)
// into a single-beat AXI4 read and returns lane-aligned data with a one-cycle
// if_ready pulse. Only one read is ever outstanding.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   if_valid/inst_addr/ fetch request from IF; held by IF until if_ready
//   if_size
//   if_ready            one-cycle pulse, if_data_read/if_resp valid
//   if_data_read        fetched beat shifted so the requested bytes start at bit 0
//   if_resp             rresp of the completed beat
//   ar*                 AXI read-address channel (master side)
//   r*                  AXI read-data channel (master side); rlast/rid unchecked
module ysyx_22040759_if_axi_rd #(
  parameter int                     AXI_ADDR_W = 32,
  parameter int                     AXI_DATA_W = 64,
  parameter int                     AXI_ID_W   = 4,
  parameter logic [AXI_ID_W-1:0]    AXI_ID     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [63:0]           inst_addr,
  input  logic [1:0]            if_size,
  output logic                  if_ready,
  output logic [AXI_DATA_W-1:0] if_data_read,
  output logic [1:0]            if_resp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [AXI_DATA_W-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic [AXI_ID_W-1:0]   rid
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [1:0]              size_q;
  logic [5:0]              lane_shift;

  // rlast/rid carry no information for a single-beat read; upper address bits
  // beyond the AXI address width are intentionally dropped.
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rid, inst_addr};

  // Byte offset within the 64-bit beat, expressed in bits.
  assign lane_shift = {addr_q[2:0], 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      if_data_read <= '0;
      if_resp      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && if_valid) begin
        addr_q <= inst_addr[AXI_ADDR_W-1:0];
        size_q <= if_size;
      end
      if (state == R && rvalid) begin
        if_data_read <= rdata >> lane_shift;
        if_resp      <= rresp;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    if_ready  = 1'b0;
    case (state)
      IDLE: if (if_valid) state_nxt = AR;
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      DONE: begin
        if_ready  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;

endmodule
